dma_xfer_engine: RTL

//  Data mover behind the DMA register block. It takes the src/dst/len configuration and a start pulse.
//  It reads len 32-bit words from src over the ICB master port into a small FIFO. It then writes them to dst.

---
 rtl/dma_xfer_engine.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine
//   Moves xfer_len 32-bit words from src_addr to dst_addr over a single ICB master port.
//   Words are read into a small FIFO in batches of up to FIFO_DEPTH. Each batch is then
//   written out before the next read batch starts. Only one ICB command is outstanding at
//   any time. A one-cycle done pulse marks the end of every accepted start, including len=0.
//
//   Optional feature macro: DMA_ERR_ABORT_EN
//     defined   : a response with rsp_err set raises err, drops the word, flushes the FIFO
//                 and finishes the transfer early (done still pulses).
//     undefined : rsp_err only raises the sticky err flag; the transfer runs to completion.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    one-cycle request, accepted only while busy=0
//   src_addr/dst_addr        word-aligned byte addresses, sampled on an accepted start
//   xfer_len                 word count, sampled on an accepted start
//   busy, done, err          status: in-progress, completion pulse, sticky bus error
//   dma_icb_cmd_*            ICB command channel (master)
//   dma_icb_rsp_*            ICB response channel (master)
module dma_xfer_engine #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] xfer_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dma_icb_cmd_valid,
    input  logic             dma_icb_cmd_ready,
    output logic             dma_icb_cmd_read,
    output logic [31:0]      dma_icb_cmd_addr,
    output logic [31:0]      dma_icb_cmd_wdata,
    output logic [3:0]       dma_icb_cmd_wmask,
    input  logic             dma_icb_rsp_valid,
    output logic             dma_icb_rsp_ready,
    input  logic [31:0]      dma_icb_rsp_rdata,
    input  logic             dma_icb_rsp_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdRsp,
        StWrCmd,
        StWrRsp,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_cnt_q;
    logic [LEN_W-1:0] wr_cnt_q;
    logic             err_q;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] fcnt_q;

    logic cmd_hsk;
    logic rsp_hsk;
    logic start_acc;
    logic abort;
    logic push;
    logic pop;
    logic last_rd;
    logic last_wr;
    logic fifo_full_nxt;
    logic fifo_empty_nxt;

    assign cmd_hsk   = dma_icb_cmd_valid & dma_icb_cmd_ready;
    assign rsp_hsk   = dma_icb_rsp_valid & dma_icb_rsp_ready;
    assign start_acc = (state_q == StIdle) & start;

`ifdef DMA_ERR_ABORT_EN
    assign abort = rsp_hsk & dma_icb_rsp_err;
`else
    assign abort = 1'b0;
`endif

    // Reads and writes never overlap, so push and pop are mutually exclusive.
    assign push = (state_q == StRdRsp) & rsp_hsk & ~abort;
    assign pop  = (state_q == StWrRsp) & rsp_hsk & ~abort;

    // Decisions are made on the values the counters take after the current beat.
    assign last_rd        = (rd_cnt_q + LEN_W'(1)) == len_q;
    assign last_wr        = (wr_cnt_q + LEN_W'(1)) == len_q;
    assign fifo_full_nxt  = (fcnt_q + CNT_W'(1)) == CNT_W'(FIFO_DEPTH);
    assign fifo_empty_nxt = fcnt_q == CNT_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (xfer_len == '0) ? StDone : StRdCmd;
                end
            end
            StRdCmd: begin
                if (cmd_hsk) state_d = StRdRsp;
            end
            StRdRsp: begin
                if (rsp_hsk) begin
                    if (abort) begin
                        state_d = StDone;
                    end else if (fifo_full_nxt || last_rd) begin
                        state_d = StWrCmd;
                    end else begin
                        state_d = StRdCmd;
                    end
                end
            end
            StWrCmd: begin
                if (cmd_hsk) state_d = StWrRsp;
            end
            StWrRsp: begin
                if (rsp_hsk) begin
                    if (abort || last_wr) begin
                        state_d = StDone;
                    end else if (fifo_empty_nxt) begin
                        state_d = StRdCmd;
                    end else begin
                        state_d = StWrCmd;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; command fields depend only on registered state, so they hold through a stall.
    always_comb begin
        busy              = state_q != StIdle;
        done              = state_q == StDone;
        err               = err_q;
        dma_icb_cmd_valid = 1'b0;
        dma_icb_cmd_read  = 1'b0;
        dma_icb_cmd_addr  = '0;
        dma_icb_cmd_wdata = '0;
        dma_icb_cmd_wmask = 4'h0;
        dma_icb_rsp_ready = 1'b0;
        unique case (state_q)
            StRdCmd: begin
                dma_icb_cmd_valid = 1'b1;
                dma_icb_cmd_read  = 1'b1;
                dma_icb_cmd_addr  = src_q + (32'(rd_cnt_q) << 2);
            end
            StWrCmd: begin
                dma_icb_cmd_valid = 1'b1;
                dma_icb_cmd_addr  = dst_q + (32'(wr_cnt_q) << 2);
                dma_icb_cmd_wdata = fifo_mem[rptr_q];
                dma_icb_cmd_wmask = 4'hF;
            end
            StRdRsp, StWrRsp: begin
                dma_icb_rsp_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Configuration, counters, error flag and FIFO bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fcnt_q   <= '0;
        end else begin
            if (start_acc) begin
                src_q    <= src_addr;
                dst_q    <= dst_addr;
                len_q    <= xfer_len;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
                err_q    <= 1'b0;
            end else if (rsp_hsk && dma_icb_rsp_err) begin
                err_q <= 1'b1;
            end

            if (push) begin
                rd_cnt_q <= rd_cnt_q + LEN_W'(1);
                wptr_q   <= wptr_q + PTR_W'(1);
                fcnt_q   <= fcnt_q + CNT_W'(1);
            end
            if (pop) begin
                wr_cnt_q <= wr_cnt_q + LEN_W'(1);
                rptr_q   <= rptr_q + PTR_W'(1);
                fcnt_q   <= fcnt_q - CNT_W'(1);
            end

            // An aborted transfer leaves nothing behind for the next one.
            if (abort || start_acc) begin
                wptr_q <= '0;
                rptr_q <= '0;
                fcnt_q <= '0;
            end
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= dma_icb_rsp_rdata;
        end
    end

endmodule
